// File: rtl/poly_key_voice_alloc.sv
// poly_key_voice_alloc
// Polyphonic keyboard front end. Takes whole HID keyboard reports, maps each
// keycode to a note number and assigns held notes to NUM_VOICES voices. It
// emits at most one registered note-on/note-off event per cycle. When every
// voice is busy, the oldest voice is stolen.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   report_valid      report_keys holds a new report
//   report_keys       NUM_KEYS slots of 8 bits; slot k = [8k+7:8k]; 0x00 = empty
//   report_ready      high only in IDLE
//   voice_active      bit v = voice v sounding
//   voice_note        note held by voice v at [v*NOTE_W +: NOTE_W]; 0 if inactive
//   event_valid       one-cycle pulse per event
//   event_on          1 = note-on, 0 = note-off
//   event_steal       note-on displaced an active note
//   event_voice       voice index of the event
//   event_note        old note for off, new note for on
//   dbg_state         current FSM state (0 idle, 1 release, 2 press)
//
// Handshake: a report transfers on a rising edge where report_valid and
// report_ready are both high. report_valid seen while report_ready is low is
// ignored, so the source must hold it. Events have no backpressure: the
// consumer must take every event_valid pulse.
module poly_key_voice_alloc #(
  parameter int NUM_KEYS   = 6,
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 6,
  parameter int AGE_W      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           report_valid,
  input  logic [NUM_KEYS*8-1:0]          report_keys,
  output logic                           report_ready,
  output logic [NUM_VOICES-1:0]          voice_active,
  output logic [NUM_VOICES*NOTE_W-1:0]   voice_note,
  output logic                           event_valid,
  output logic                           event_on,
  output logic                           event_steal,
  output logic [$clog2(NUM_VOICES)-1:0]  event_voice,
  output logic [NOTE_W-1:0]              event_note,
  output logic [1:0]                     dbg_state
);

  localparam int VW    = $clog2(NUM_VOICES);
  localparam int IDX_W = $clog2(NUM_VOICES + NUM_KEYS);
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RELEASE = 2'd1,
    S_PRESS   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_KEYS*8-1:0]   keys_q, keys_d;
  logic                    roll_q, roll_d;
  logic [NUM_VOICES-1:0]   active_q, active_d;
  logic [NOTE_W-1:0]       note_q [NUM_VOICES];
  logic [NOTE_W-1:0]       note_d [NUM_VOICES];
  logic [AGE_W-1:0]        age_q  [NUM_VOICES];
  logic [AGE_W-1:0]        age_d  [NUM_VOICES];
  logic                    ev_valid_q, ev_valid_d;
  logic                    ev_on_q, ev_on_d;
  logic                    ev_steal_q, ev_steal_d;
  logic [VW-1:0]           ev_voice_q, ev_voice_d;
  logic [NOTE_W-1:0]       ev_note_q, ev_note_d;

  // Scratch values for the PRESS step.
  logic [7:0]              slot_key;
  logic [NOTE_W:0]         slot_map;
  logic                    held;
  logic                    free_found;
  logic [VW-1:0]           sel;
  logic [AGE_W-1:0]        best_age;
  logic                    rollover;

  // Returns {mapped, note}.
  function automatic logic [NOTE_W:0] map_key(input logic [7:0] k);
    logic [NOTE_W:0] r;
    r = '0;
    if (k >= 8'd30 && k <= 8'd39) begin
      r = {1'b1, NOTE_W'(k - 8'd29)};
    end else begin
      case (k)
        8'd53: r = {1'b1, NOTE_W'(0)};
        8'd45: r = {1'b1, NOTE_W'(11)};
        8'd43: r = {1'b1, NOTE_W'(12)};
        8'd20: r = {1'b1, NOTE_W'(13)};
        8'd26: r = {1'b1, NOTE_W'(14)};
        8'd8:  r = {1'b1, NOTE_W'(15)};
        8'd21: r = {1'b1, NOTE_W'(16)};
        8'd23: r = {1'b1, NOTE_W'(17)};
        8'd28: r = {1'b1, NOTE_W'(18)};
        8'd24: r = {1'b1, NOTE_W'(19)};
        8'd12: r = {1'b1, NOTE_W'(20)};
        8'd18: r = {1'b1, NOTE_W'(21)};
        8'd19: r = {1'b1, NOTE_W'(22)};
        8'd47: r = {1'b1, NOTE_W'(23)};
        8'd57: r = {1'b1, NOTE_W'(24)};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  // True when any mapped slot of the report produces note n.
  function automatic logic in_report(input logic [NUM_KEYS*8-1:0] keys,
                                     input logic [NOTE_W-1:0] n);
    logic [NOTE_W:0] m;
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      m = map_key(keys[k*8 +: 8]);
      if (m[NOTE_W] && m[NOTE_W-1:0] == n) hit = 1'b1;
    end
    return hit;
  endfunction

  // Error-rollover codes 0x01..0x03 in any slot mark the report as unusable.
  always_comb begin
    rollover = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (report_keys[k*8 +: 8] >= 8'd1 && report_keys[k*8 +: 8] <= 8'd3)
        rollover = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    keys_d     = keys_q;
    roll_d     = roll_q;
    active_d   = active_q;
    note_d     = note_q;
    age_d      = age_q;
    ev_valid_d = 1'b0;
    ev_on_d    = 1'b0;
    ev_steal_d = 1'b0;
    ev_voice_d = '0;
    ev_note_d  = '0;
    slot_key   = '0;
    slot_map   = '0;
    held       = 1'b0;
    free_found = 1'b0;
    sel        = '0;
    best_age   = '0;

    case (state_q)
      S_IDLE: begin
        if (report_valid) begin
          keys_d  = report_keys;
          roll_d  = rollover;
          idx_d   = '0;
          state_d = S_RELEASE;
        end
      end

      S_RELEASE: begin
        // A rollover report still walks the full scan so timing is uniform;
        // it just never touches voice state.
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (idx_q == IDX_W'(v) && !roll_q && active_q[v] &&
              !in_report(keys_q, note_q[v])) begin
            active_d[v] = 1'b0;
            note_d[v]   = '0;
            ev_valid_d  = 1'b1;
            ev_voice_d  = VW'(v);
            ev_note_d   = note_q[v];
          end
        end
        if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
          idx_d   = '0;
          state_d = S_PRESS;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_PRESS: begin
        for (int k = 0; k < NUM_KEYS; k++) begin
          if (idx_q == IDX_W'(k)) slot_key = keys_q[k*8 +: 8];
        end
        slot_map = map_key(slot_key);
        // Voice state already includes allocations from earlier slots of this
        // scan, so duplicates and same-note keys collapse onto one voice.
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (active_q[v] && note_q[v] == slot_map[NOTE_W-1:0]) held = 1'b1;
        end
        // Lowest free voice: scan downwards so the lowest index wins.
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
          if (!active_q[v]) begin
            free_found = 1'b1;
            sel        = VW'(v);
          end
        end
        // No free voice: oldest wins, strict compare keeps the lowest index on ties.
        if (!free_found) begin
          best_age = age_q[0];
          for (int v = 1; v < NUM_VOICES; v++) begin
            if (age_q[v] > best_age) begin
              best_age = age_q[v];
              sel      = VW'(v);
            end
          end
        end
        if (!roll_q && slot_map[NOTE_W] && !held) begin
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (sel == VW'(v)) begin
              active_d[v] = 1'b1;
              note_d[v]   = slot_map[NOTE_W-1:0];
              age_d[v]    = '0;
            end else if (active_q[v] && age_q[v] != AGE_MAX) begin
              age_d[v] = age_q[v] + 1'b1;
            end
          end
          ev_valid_d = 1'b1;
          ev_on_d    = 1'b1;
          ev_steal_d = !free_found;
          ev_voice_d = sel;
          ev_note_d  = slot_map[NOTE_W-1:0];
        end
        if (idx_q == IDX_W'(NUM_KEYS - 1)) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      keys_q     <= '0;
      roll_q     <= 1'b0;
      active_q   <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= '0;
        age_q[v]  <= '0;
      end
      ev_valid_q <= 1'b0;
      ev_on_q    <= 1'b0;
      ev_steal_q <= 1'b0;
      ev_voice_q <= '0;
      ev_note_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      keys_q     <= keys_d;
      roll_q     <= roll_d;
      active_q   <= active_d;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= note_d[v];
        age_q[v]  <= age_d[v];
      end
      ev_valid_q <= ev_valid_d;
      ev_on_q    <= ev_on_d;
      ev_steal_q <= ev_steal_d;
      ev_voice_q <= ev_voice_d;
      ev_note_q  <= ev_note_d;
    end
  end

  always_comb begin
    voice_note = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_note[v*NOTE_W +: NOTE_W] = note_q[v];
    end
  end

  assign report_ready = (state_q == S_IDLE);
  assign voice_active = active_q;
  assign event_valid  = ev_valid_q;
  assign event_on     = ev_on_q;
  assign event_steal  = ev_steal_q;
  assign event_voice  = ev_voice_q;
  assign event_note   = ev_note_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_poly_key_voice_alloc.sv
// Directed testbench for poly_key_voice_alloc with default parameters.
// Events are packed as {on, steal, voice[1:0], note[5:0]}.
module tb_poly_key_voice_alloc;

  localparam int NUM_KEYS   = 6;
  localparam int NUM_VOICES = 4;
  localparam int NOTE_W     = 6;
  localparam int SCAN       = NUM_VOICES + NUM_KEYS;

  logic                          clk;
  logic                          rst;
  logic                          report_valid;
  logic [NUM_KEYS*8-1:0]         report_keys;
  logic                          report_ready;
  logic [NUM_VOICES-1:0]         voice_active;
  logic [NUM_VOICES*NOTE_W-1:0]  voice_note;
  logic                          event_valid;
  logic                          event_on;
  logic                          event_steal;
  logic [1:0]                    event_voice;
  logic [NOTE_W-1:0]             event_note;
  logic [1:0]                    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int ready_low;

  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];

  poly_key_voice_alloc dut (
    .clk          (clk),
    .rst          (rst),
    .report_valid (report_valid),
    .report_keys  (report_keys),
    .report_ready (report_ready),
    .voice_active (voice_active),
    .voice_note   (voice_note),
    .event_valid  (event_valid),
    .event_on     (event_on),
    .event_steal  (event_steal),
    .event_voice  (event_voice),
    .event_note   (event_note),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] ev(input logic on, input logic steal,
                                    input logic [1:0] voice, input logic [5:0] note);
    return {on, steal, voice, note};
  endfunction

  function automatic logic [47:0] keys6(input logic [7:0] k0, input logic [7:0] k1,
                                        input logic [7:0] k2, input logic [7:0] k3,
                                        input logic [7:0] k4, input logic [7:0] k5);
    return {k5, k4, k3, k2, k1, k0};
  endfunction

  // Driver: waits (bounded) for ready, presents one report for one accept
  // edge, then records events and ready-low cycles over the whole scan.
  task automatic run_report(input logic [47:0] keys);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!report_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_send", {31'd0, report_ready}, 32'd1);
    report_keys  = keys;
    report_valid = 1'b1;
    @(posedge clk);
    #1;
    report_valid = 1'b0;
    report_keys  = '0;
    ready_low = 0;
    for (int c = 0; c < SCAN + 2; c++) begin
      @(negedge clk);
      if (!report_ready) ready_low++;
      if (event_valid) got_q.push_back({event_on, event_steal, event_voice, event_note});
    end
  endtask

  // Scoreboard: compares recorded events against the expected queue.
  task automatic compare_events(input string tag);
    logic [9:0] g;
    logic [9:0] e;
    check({tag, "_ev_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_event"}, {22'd0, g}, {22'd0, e});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int guard;
    rst          = 1'b1;
    report_valid = 1'b0;
    report_keys  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",  {31'd0, report_ready}, 32'd1);
    check("rst_active", {28'd0, voice_active}, 32'd0);
    check("rst_notes",  {8'd0, voice_note}, 32'd0);
    check("rst_event",  {31'd0, event_valid}, 32'd0);
    rst = 1'b0;

    // Press Q
    exp_q.push_back(ev(1, 0, 0, 13));
    run_report(keys6(20, 0, 0, 0, 0, 0));
    compare_events("press_q");
    check("press_q_ready_low", ready_low, SCAN);
    check("press_q_active", {28'd0, voice_active}, 32'h1);
    check("press_q_note0", {26'd0, voice_note[5:0]}, 32'd13);

    // Release all
    exp_q.push_back(ev(0, 0, 0, 13));
    run_report('0);
    compare_events("empty");
    check("empty_active", {28'd0, voice_active}, 32'h0);
    check("empty_note0", {26'd0, voice_note[5:0]}, 32'd0);

    // Duplicates and an unmapped keycode
    exp_q.push_back(ev(1, 0, 0, 13));
    exp_q.push_back(ev(1, 0, 1, 15));
    run_report(keys6(20, 20, 8, 99, 0, 0));
    compare_events("dup");
    check("dup_active", {28'd0, voice_active}, 32'h3);

    // Fill all four voices; the old two are released first
    exp_q.push_back(ev(0, 0, 0, 13));
    exp_q.push_back(ev(0, 0, 1, 15));
    exp_q.push_back(ev(1, 0, 0, 1));
    exp_q.push_back(ev(1, 0, 1, 2));
    exp_q.push_back(ev(1, 0, 2, 3));
    exp_q.push_back(ev(1, 0, 3, 4));
    run_report(keys6(30, 31, 32, 33, 0, 0));
    compare_events("fill");
    check("fill_active", {28'd0, voice_active}, 32'hF);

    // Fifth note steals oldest voice 0 (slot 0..3 notes still held)
    exp_q.push_back(ev(1, 1, 0, 5));
    run_report(keys6(30, 31, 32, 33, 34, 0));
    compare_events("steal");
    check("steal_notes", {8'd0, voice_note}, {8'd0, 6'd4, 6'd3, 6'd2, 6'd5});

    // No-change report: nothing happens, timing unchanged
    run_report(keys6(31, 32, 33, 34, 0, 0));
    compare_events("nochange");
    check("nochange_ready_low", ready_low, SCAN);

    // Release note 2 (voice 1), then reuse the freed voice without stealing
    exp_q.push_back(ev(0, 0, 1, 2));
    run_report(keys6(32, 33, 34, 0, 0, 0));
    compare_events("rel_v1");
    exp_q.push_back(ev(1, 0, 1, 6));
    run_report(keys6(32, 33, 34, 35, 0, 0));
    compare_events("reuse_v1");
    check("reuse_notes", {8'd0, voice_note}, {8'd0, 6'd4, 6'd3, 6'd6, 6'd5});

    // Down to two voices (v0 note 5, v3 note 4), then rollover reports
    exp_q.push_back(ev(0, 0, 1, 6));
    exp_q.push_back(ev(0, 0, 2, 3));
    run_report(keys6(33, 34, 0, 0, 0, 0));
    compare_events("two_left");
    run_report(keys6(1, 1, 1, 1, 1, 1));
    compare_events("rollover");
    check("rollover_ready_low", ready_low, SCAN);
    check("rollover_active", {28'd0, voice_active}, 32'h9);
    check("rollover_notes", {8'd0, voice_note}, {8'd0, 6'd4, 6'd0, 6'd0, 6'd5});
    run_report(keys6(20, 2, 0, 0, 0, 0));
    compare_events("rollover_mixed");
    check("rollover_mixed_active", {28'd0, voice_active}, 32'h9);

    // Three voices active, then reset in the middle of a PRESS scan
    exp_q.push_back(ev(0, 0, 0, 5));
    exp_q.push_back(ev(0, 0, 3, 4));
    exp_q.push_back(ev(1, 0, 0, 13));
    exp_q.push_back(ev(1, 0, 1, 15));
    exp_q.push_back(ev(1, 0, 2, 16));
    run_report(keys6(20, 8, 21, 0, 0, 0));
    compare_events("three");
    check("three_active", {28'd0, voice_active}, 32'h7);

    @(negedge clk);
    report_keys  = keys6(20, 8, 21, 26, 0, 0);
    report_valid = 1'b1;
    @(posedge clk);
    #1;
    report_valid = 1'b0;
    guard = 0;
    while (dbg_state != 2'd2 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("reach_press", {30'd0, dbg_state}, 32'd2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready",  {31'd0, report_ready}, 32'd1);
    check("midrst_active", {28'd0, voice_active}, 32'd0);
    check("midrst_notes",  {8'd0, voice_note}, 32'd0);
    check("midrst_event",  {28'd0, event_valid, event_on, event_steal, 1'b0}, 32'd0);
    check("midrst_evfields", {24'd0, event_voice, event_note}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(ev(1, 0, 0, 0));
    run_report(keys6(53, 0, 0, 0, 0, 0));
    compare_events("after_rst");
    check("after_rst_active", {28'd0, voice_active}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/poly_key_voice_alloc.md
# poly_key_voice_alloc

Polyphonic successor to the single-key keycode-to-note mapper: accepts whole USB HID keyboard reports (up to NUM_KEYS simultaneous keycodes), maps each keycode to a note number, and assigns held notes to NUM_VOICES synthesizer voices. It emits one registered note-on/note-off event per cycle and steals the oldest voice when all voices are busy. It sits between the USB keyboard report path and the per-voice tone generators.

## Interface
- NUM_KEYS, 6, keycode slots per report
- NUM_VOICES, 4, voice channels (≥2)
- NOTE_W, 6, note number width
- AGE_W, 4, per-voice saturating age counter width
- Clk  in  1  system clock; all state on rising edge
- Reset  in  1  asynchronous, active-high
- report_valid  in  1  report_keys holds a new report
- report_keys  in  NUM_KEYS*8  slot k = bits [8k+7:8k]; 0x00 = empty slot
- report_ready  out  1  high only in IDLE; report accepted when valid&&ready
- voice_active  out  NUM_VOICES  bit v = voice v sounding
- voice_note  out  NUM_VOICES*NOTE_W  note held by voice v (0 when inactive)
- event_valid  out  1  one-cycle pulse per event
- event_on  out  1  1 = note-on, 0 = note-off
- event_steal  out  1  note-on displaced an active note
- event_voice  out  $clog2(NUM_VOICES)  voice index of event
- event_note  out  NOTE_W  note of event (old note for off, new note for on)

## Operation
- Fixed map (keycode→note): 53→0, 30..39→1..10, 45→11, 43→12, 20→13, 26→14, 8→15, 21→16, 23→17, 28→18, 24→19, 12→20, 18→21, 19→22, 47→23, 57→24. Every other keycode is unmapped and ignored.
- FSM: IDLE → RELEASE → PRESS → IDLE.
- IDLE: report_ready=1; on accept, latch report_keys.
- Rollover report: if any latched slot is 0x01, 0x02 or 0x03, skip RELEASE and PRESS. Return to IDLE after the normal scan length with no events and no state change.
- RELEASE: one voice per cycle, index 0..NUM_VOICES-1. If a voice is active and its note matches no mapped slot of the latched report, clear the voice and emit an off event.
- PRESS: one slot per cycle, index 0..NUM_KEYS-1. If the slot is mapped and its note is not held by any voice (including voices allocated earlier in this scan), allocate:
  - lowest-index inactive voice; otherwise
  - active voice with the largest age, ties to lowest index. Emit an on event with event_steal=1; no separate off event for the stolen note.
- Age: on each allocation, the allocated voice age=0 and every other active voice age+1, saturating at 2^AGE_W-1. Inactive voice age is don't-care, reset to 0.
- Duplicate keycodes and distinct keys mapping to the same note yield one voice.

## Timing
- Accept in cycle 0. RELEASE occupies cycles 1..NUM_VOICES; PRESS occupies NUM_VOICES+1..NUM_VOICES+NUM_KEYS.
- report_ready is low for exactly NUM_VOICES+NUM_KEYS cycles after accept and returns high the next cycle. This holds for all reports, including rollover and no-change reports.
- An event for a step is registered: visible in the cycle after that step's scan cycle. voice_active/voice_note update in the same cycle as their event.
- At most one event per cycle; no backpressure, so the consumer must take every pulse.
- report_valid while report_ready=0 is ignored; the source holds it.
- Reset (any time, including mid-scan): state=IDLE, report_ready=1, voice_active=0, voice_note=0, ages=0, event_valid=event_on=event_steal=0, event_voice=event_note=0. No off events are emitted for voices cleared by reset.

## Test plan
- Press Q (keys={20,0,0,0,0,0}) → one event: on, voice 0, note 13, steal=0; voice_active=0001; report_ready returns after 10 cycles (defaults).
- Follow with an empty report → one event: off, voice 0, note 13; voice_active=0000.
- Report {20,20,8,99,0,0} → exactly two on events: 13 on voice 0, 15 on voice 1; keycode 99 produces nothing.
- Hold {30,31,32,33}, then send {30,31,32,33,34} → one event: on, note 5, voice 0 (oldest), steal=1; voice 0 age resets.
- With 2 voices active, send {1,1,1,1,1,1} → no events, voices unchanged, ready low for 10 cycles.
- Assert Reset during PRESS with 3 voices active → all outputs at reset values immediately; next report {53} gives on, note 0, voice 0.
